// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, drives a req/ack instruction-memory
// port, and feeds the F/D boundary through a registered slot plus one-entry skid.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | one cycle after reset, no request outstanding
// REQ   | request to fpc outstanding, waiting for ack
// SKID  | slot stalled and full, skid holds the next instruction, no request
// DRAIN | abandoned request still outstanding; redirect target parked in fpc_next
module fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_d_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             mem_req_o,
    output logic [WIDTH-1:0] mem_addr_o,
    input  logic             mem_ack_i,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic [WIDTH-1:0] pcf_o,
    output logic [WIDTH-1:0] pcplus4f_o,
    output logic [WIDTH-1:0] instrf_o,
    output logic             validf_o,
    output logic [31:0]      fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_SKID  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] fpc, fpc_d;
    logic [WIDTH-1:0] fpc_next, fpc_next_d;
    logic [WIDTH-1:0] pcf, pcf_d;
    logic [WIDTH-1:0] instrf, instrf_d;
    logic             validf, validf_d;
    logic [WIDTH-1:0] skid_pc, skid_pc_d;
    logic [WIDTH-1:0] skid_instr, skid_instr_d;
    logic [31:0]      fetch_cnt, fetch_cnt_d;
    logic             slot_free;

    assign slot_free   = !validf || !stall_d_i;
    assign mem_addr_o  = fpc;
    assign pcf_o       = pcf;
    assign pcplus4f_o  = pcf + WIDTH'(4);
    assign instrf_o    = instrf;
    assign validf_o    = validf;
    assign fetch_cnt_o = fetch_cnt;

    // State, PC, slot and skid registers; reset is immediate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            fpc        <= RESET_PC;
            fpc_next   <= RESET_PC;
            pcf        <= '0;
            instrf     <= '0;
            validf     <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
            fetch_cnt  <= '0;
        end else begin
            state      <= state_d;
            fpc        <= fpc_d;
            fpc_next   <= fpc_next_d;
            pcf        <= pcf_d;
            instrf     <= instrf_d;
            validf     <= validf_d;
            skid_pc    <= skid_pc_d;
            skid_instr <= skid_instr_d;
            fetch_cnt  <= fetch_cnt_d;
        end
    end

    // Next-state and request logic; redirect beats everything else, and an
    // ack arriving with a redirect is always thrown away.
    always_comb begin
        state_d      = state;
        fpc_d        = fpc;
        fpc_next_d   = fpc_next;
        pcf_d        = pcf;
        instrf_d     = instrf;
        validf_d     = validf;
        skid_pc_d    = skid_pc;
        skid_instr_d = skid_instr;
        fetch_cnt_d  = fetch_cnt;
        mem_req_o    = 1'b0;

        case (state)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_i) begin
                    fpc_d    = redirect_pc_i;
                    validf_d = 1'b0;
                end
            end

            S_REQ: begin
                mem_req_o = 1'b1;
                if (redirect_i) begin
                    validf_d = 1'b0;
                    if (mem_ack_i) begin
                        fpc_d   = redirect_pc_i;
                        state_d = S_REQ;
                    end else begin
                        fpc_next_d = redirect_pc_i;
                        state_d    = S_DRAIN;
                    end
                end else if (mem_ack_i) begin
                    fpc_d = fpc + WIDTH'(4);
                    if (slot_free) begin
                        pcf_d       = fpc;
                        instrf_d    = mem_rdata_i;
                        validf_d    = 1'b1;
                        fetch_cnt_d = fetch_cnt + 32'd1;
                    end else begin
                        skid_pc_d    = fpc;
                        skid_instr_d = mem_rdata_i;
                        state_d      = S_SKID;
                    end
                end else if (slot_free) begin
                    validf_d = 1'b0;
                end
            end

            S_SKID: begin
                if (redirect_i) begin
                    validf_d = 1'b0;
                    fpc_d    = redirect_pc_i;
                    state_d  = S_REQ;
                end else if (!stall_d_i) begin
                    pcf_d       = skid_pc;
                    instrf_d    = skid_instr;
                    validf_d    = 1'b1;
                    fetch_cnt_d = fetch_cnt + 32'd1;
                    state_d     = S_REQ;
                end
            end

            S_DRAIN: begin
                mem_req_o = 1'b1;
                if (redirect_i) begin
                    validf_d = 1'b0;
                    if (mem_ack_i) begin
                        fpc_d   = redirect_pc_i;
                        state_d = S_REQ;
                    end else begin
                        fpc_next_d = redirect_pc_i;
                    end
                end else if (mem_ack_i) begin
                    fpc_d   = fpc_next;
                    state_d = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
